// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - 8-bit PC sequencer driving the datapath mux and the instruction fetch handshake.
// Optional call/return link register enabled by defining PC_LINK_EN.
module pc_sequencer #(
   parameter logic [7:0] RESET_PC   = 8'h00,
   parameter int         WAIT_LIMIT = 15
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       Start,
   input  logic       Halt,
   input  logic       Branch_Req,
   input  logic [7:0] Branch_Addr,
   input  logic       Mem_Ack,
   input  logic [7:0] Mux_In,
`ifdef PC_LINK_EN
   input  logic       Call_Req,
   input  logic       Ret_Req,
   output logic [7:0] Link,
`endif
   output logic [7:0] Next_Seq,
   output logic [7:0] Next_Branch,
   output logic       Mux_Sel,
   output logic [7:0] PC,
   output logic       Mem_Req,
   output logic       Fetch_Valid,
   output logic       Timeout,
   output logic [1:0] State
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_FETCH  = 2'b01,
      S_WAIT   = 2'b10,
      S_HALTED = 2'b11
   } state_t;

   localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

   state_t     state_q;
   logic       br_pending;
   logic       halt_pending;
   logic [7:0] wait_cnt;
   logic [7:0] wait_cnt_inc;
   logic       active;
   logic       accept;
   logic       req_any;
   logic [7:0] req_target;

   assign State        = state_q;
   assign active       = (state_q == S_FETCH) || (state_q == S_WAIT);
   assign accept       = active && Mem_Ack;
   assign Mem_Req      = active;
   assign Mux_Sel      = br_pending;
   assign Next_Seq     = PC + 8'd1;
   assign wait_cnt_inc = wait_cnt + 8'd1;

`ifdef PC_LINK_EN
   logic call_pending;
   assign req_any    = Ret_Req || Call_Req || Branch_Req;
   assign req_target = Ret_Req ? Link : Branch_Addr;

   // Link captures the return address when the fetch that consumes a call target is accepted.
   always_ff @(posedge CLK) begin
      if (RST) begin
         Link         <= 8'h00;
         call_pending <= 1'b0;
      end else begin
         if (accept) begin
            if (call_pending) Link <= PC + 8'd1;
            call_pending <= 1'b0;
         end
         if (req_any && state_q != S_HALTED)
            call_pending <= Call_Req && !Ret_Req;
      end
   end
`else
   assign req_any    = Branch_Req;
   assign req_target = Branch_Addr;
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= S_IDLE;
         PC           <= RESET_PC;
         Fetch_Valid  <= 1'b0;
         Timeout      <= 1'b0;
         br_pending   <= 1'b0;
         Next_Branch  <= 8'h00;
         halt_pending <= 1'b0;
         wait_cnt     <= 8'h00;
      end else begin
         Fetch_Valid <= accept;
         case (state_q)
            S_IDLE: begin
               if (Halt)       state_q <= S_HALTED;
               else if (Start) state_q <= S_FETCH;
            end
            S_FETCH, S_WAIT: begin
               if (Mem_Ack) begin
                  PC           <= Mux_In;
                  br_pending   <= 1'b0;
                  halt_pending <= 1'b0;
                  state_q      <= (halt_pending || Halt) ? S_HALTED : S_FETCH;
               end else begin
                  if (Halt) halt_pending <= 1'b1;
                  if (state_q == S_FETCH) begin
                     state_q  <= S_WAIT;
                     wait_cnt <= 8'h00;
                  end else begin
                     wait_cnt <= wait_cnt_inc;
                     // Give up on the fetch; PC still points at the unanswered address.
                     if (wait_cnt_inc == LIMIT) begin
                        Timeout      <= 1'b1;
                        state_q      <= S_HALTED;
                        halt_pending <= 1'b0;
                     end
                  end
               end
            end
            default: begin
               if (Start) begin
                  state_q <= S_FETCH;
                  Timeout <= 1'b0;
               end
            end
         endcase
         // A request in the accepting cycle re-arms the branch for the following fetch.
         if (req_any && state_q != S_HALTED) begin
            br_pending  <= 1'b1;
            Next_Branch <= req_target;
         end
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - Directed table-driven bench for pc_sequencer with a zero-latency mux model.
module tb_pc_sequencer;

   logic       CLK = 1'b0;
   logic       RST, Start, Halt, Branch_Req, Mem_Ack;
   logic [7:0] Branch_Addr, Mux_In;
   logic [7:0] Next_Seq, Next_Branch, PC;
   logic       Mux_Sel, Mem_Req, Fetch_Valid, Timeout;
   logic [1:0] State;
`ifdef PC_LINK_EN
   logic       Call_Req = 1'b0, Ret_Req = 1'b0;
   logic [7:0] Link;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 CLK = ~CLK;

   assign Mux_In = Mux_Sel ? Next_Branch : Next_Seq;

   pc_sequencer #(.RESET_PC(8'h00), .WAIT_LIMIT(15)) dut (
      .CLK(CLK), .RST(RST), .Start(Start), .Halt(Halt),
      .Branch_Req(Branch_Req), .Branch_Addr(Branch_Addr),
      .Mem_Ack(Mem_Ack), .Mux_In(Mux_In),
`ifdef PC_LINK_EN
      .Call_Req(Call_Req), .Ret_Req(Ret_Req), .Link(Link),
`endif
      .Next_Seq(Next_Seq), .Next_Branch(Next_Branch), .Mux_Sel(Mux_Sel),
      .PC(PC), .Mem_Req(Mem_Req), .Fetch_Valid(Fetch_Valid),
      .Timeout(Timeout), .State(State)
   );

   typedef struct {
      logic       rst, start, halt, br;
      logic [7:0] addr;
      logic       ack;
      logic [7:0] pc;
      logic [1:0] st;
      logic       mreq, fv, sel;
   } vec_t;

   vec_t vq[$];

   localparam logic [1:0] ID = 2'b00, FE = 2'b01, WT = 2'b10, HA = 2'b11;

   function automatic void v(input logic rst, start, halt, br, input logic [7:0] addr,
                             input logic ack, input logic [7:0] pc, input logic [1:0] st,
                             input logic mreq, fv, sel);
      vec_t t;
      t.rst = rst; t.start = start; t.halt = halt; t.br = br; t.addr = addr; t.ack = ack;
      t.pc = pc; t.st = st; t.mreq = mreq; t.fv = fv; t.sel = sel;
      vq.push_back(t);
   endfunction

   task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input logic rst, start, halt, br, input logic [7:0] addr, input logic ack);
      RST = rst; Start = start; Halt = halt; Branch_Req = br; Branch_Addr = addr; Mem_Ack = ack;
      @(posedge CLK);
      #1;
   endtask

   initial begin
      //  rst st hl br addr   ack   pc     st mrq fv sel
      v(1, 0, 0, 0, 8'h00, 0, 8'h00, ID, 0, 0, 0);   // reset
      v(0, 1, 0, 0, 8'h00, 0, 8'h00, FE, 1, 0, 0);   // start
      v(0, 0, 0, 0, 8'h00, 1, 8'h01, FE, 1, 1, 0);
      v(0, 0, 0, 0, 8'h00, 1, 8'h02, FE, 1, 1, 0);
      v(0, 0, 0, 0, 8'h00, 1, 8'h03, FE, 1, 1, 0);
      v(0, 0, 0, 0, 8'h00, 0, 8'h03, WT, 1, 0, 0);   // branch while waiting
      v(0, 0, 0, 1, 8'h40, 0, 8'h03, WT, 1, 0, 1);
      v(0, 0, 0, 0, 8'h00, 0, 8'h03, WT, 1, 0, 1);
      v(0, 0, 0, 0, 8'h00, 1, 8'h40, FE, 1, 1, 0);
      v(0, 0, 0, 0, 8'h00, 1, 8'h41, FE, 1, 1, 0);
      v(0, 0, 0, 1, 8'h10, 0, 8'h41, WT, 1, 0, 1);   // go to 10
      v(0, 0, 0, 0, 8'h00, 1, 8'h10, FE, 1, 1, 0);
      v(0, 0, 0, 1, 8'h80, 1, 8'h11, FE, 1, 1, 1);   // branch on accepting cycle
      v(0, 0, 0, 0, 8'h00, 1, 8'h80, FE, 1, 1, 0);
      v(0, 0, 0, 1, 8'hFE, 0, 8'h80, WT, 1, 0, 1);   // go to FE
      v(0, 0, 0, 0, 8'h00, 1, 8'hFE, FE, 1, 1, 0);
      v(0, 0, 0, 0, 8'h00, 1, 8'hFF, FE, 1, 1, 0);
      v(0, 0, 0, 0, 8'h00, 1, 8'h00, FE, 1, 1, 0);   // wrap
      v(0, 0, 0, 0, 8'h00, 1, 8'h01, FE, 1, 1, 0);
      v(0, 0, 0, 0, 8'h00, 0, 8'h01, WT, 1, 0, 0);   // halt while waiting
      v(0, 0, 1, 0, 8'h00, 0, 8'h01, WT, 1, 0, 0);
      v(0, 0, 0, 0, 8'h00, 0, 8'h01, WT, 1, 0, 0);
      v(0, 0, 0, 0, 8'h00, 0, 8'h01, WT, 1, 0, 0);
      v(0, 0, 0, 0, 8'h00, 1, 8'h02, HA, 0, 1, 0);
      v(0, 0, 0, 0, 8'h00, 0, 8'h02, HA, 0, 0, 0);
      v(0, 1, 0, 0, 8'h00, 0, 8'h02, FE, 1, 0, 0);
      v(0, 0, 0, 0, 8'h00, 0, 8'h02, WT, 1, 0, 0);
      v(1, 0, 0, 1, 8'h77, 1, 8'h00, ID, 0, 0, 0);   // reset mid-wait
      v(0, 1, 1, 0, 8'h00, 0, 8'h00, HA, 0, 0, 0);   // halt beats start
      v(0, 0, 0, 1, 8'h55, 0, 8'h00, HA, 0, 0, 0);   // branch ignored when halted
      v(0, 1, 0, 0, 8'h00, 0, 8'h00, FE, 1, 0, 0);
      v(0, 0, 0, 0, 8'h00, 1, 8'h01, FE, 1, 1, 0);
      v(1, 0, 0, 0, 8'h00, 0, 8'h00, ID, 0, 0, 0);
      v(0, 0, 0, 1, 8'h20, 0, 8'h00, ID, 0, 0, 1);   // branch latched in idle
      v(0, 1, 0, 0, 8'h00, 0, 8'h00, FE, 1, 0, 1);
      v(0, 0, 0, 0, 8'h00, 1, 8'h20, FE, 1, 1, 0);

      #2;
      foreach (vq[i]) begin
         drive(vq[i].rst, vq[i].start, vq[i].halt, vq[i].br, vq[i].addr, vq[i].ack);
         chk("pc", i, PC, vq[i].pc);
         chk("state", i, {6'd0, State}, {6'd0, vq[i].st});
         chk("mem_req", i, {7'd0, Mem_Req}, {7'd0, vq[i].mreq});
         chk("fetch_valid", i, {7'd0, Fetch_Valid}, {7'd0, vq[i].fv});
         chk("mux_sel", i, {7'd0, Mux_Sel}, {7'd0, vq[i].sel});
         chk("timeout", i, {7'd0, Timeout}, 8'd0);
         chk("next_seq", i, Next_Seq, vq[i].pc + 8'd1);
      end

      // Timeout: FETCH at PC=20, then 15 unanswered WAIT cycles.
      drive(0, 0, 0, 0, 8'h00, 0);
      chk("to_enter_wait", 100, {6'd0, State}, {6'd0, WT});
      for (int k = 1; k < 15; k++) begin
         drive(0, 0, 0, 0, 8'h00, 0);
         chk("to_still_wait", 100 + k, {6'd0, State}, {6'd0, WT});
      end
      drive(0, 0, 0, 0, 8'h00, 0);
      chk("to_halted", 115, {6'd0, State}, {6'd0, HA});
      chk("to_flag", 115, {7'd0, Timeout}, 8'd1);
      chk("to_pc", 115, PC, 8'h20);
      chk("to_mem_req", 115, {7'd0, Mem_Req}, 8'd0);
      drive(0, 0, 0, 0, 8'h00, 0);
      chk("to_sticky", 116, {7'd0, Timeout}, 8'd1);
      drive(0, 1, 0, 0, 8'h00, 0);
      chk("restart_state", 117, {6'd0, State}, {6'd0, FE});
      chk("restart_timeout", 117, {7'd0, Timeout}, 8'd0);
      chk("restart_pc", 117, PC, 8'h20);
      drive(0, 0, 0, 0, 8'h00, 1);
      chk("restart_fetch", 118, PC, 8'h21);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- 8-bit program-counter sequencer that sits around the 8-bit datapath mux.
- Drives both mux data inputs and the select: sequential address on Input_0, branch target on Input_1.
- Registers the mux output back as the PC.
- Runs a fetch handshake with instruction memory and handles branch, halt and timeout conditions.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.
- WAIT_LIMIT, 15, max consecutive WAIT cycles without Mem_Ack before timeout (1..255).

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- Start  in  1  leave IDLE or HALTED and begin fetching.
- Halt  in  1  request stop after the current fetch completes.
- Branch_Req  in  1  latch Branch_Addr as target for the next PC update.
- Branch_Addr  in  8  branch target.
- Mem_Ack  in  1  memory has returned the instruction at PC.
- Mux_In  in  8  from mux MUX_Out.
- Next_Seq  out  8  to mux Input_0, equals PC+1 mod 256.
- Next_Branch  out  8  to mux Input_1, latched branch target.
- Mux_Sel  out  1  to mux SEL, 1 when a branch is pending.
- PC  out  8  current fetch address.
- Mem_Req  out  1  fetch request.
- Fetch_Valid  out  1  one-cycle pulse, registered, after an accepted fetch.
- Timeout  out  1  sticky timeout flag.
- State  out  2  IDLE=00, FETCH=01, WAIT=10, HALTED=11.

Behaviour:
- Reset (RST=1 at edge): PC=RESET_PC, State=IDLE, Mem_Req=0, Fetch_Valid=0, Timeout=0, branch pending=0, Next_Branch=8'h00, halt pending=0, wait counter=0.
  - RST overrides every other input in that cycle.
  - Reset mid-fetch abandons the request; Mem_Req is 0 the next cycle.
- Mem_Req is 1 exactly in FETCH and WAIT; it is decoded from State.
- Next_Seq and Mux_Sel are combinational from registers.
- Mux_In must equal the selected mux input in the same cycle; the mux adds zero latency.
- IDLE:
  - Halt=1 goes to HALTED. Halt has priority over Start in the same cycle.
  - Otherwise Start=1 goes to FETCH.
  - Otherwise stay in IDLE.
- FETCH:
  - Mem_Ack=1 means the fetch is accepted.
  - Otherwise go to WAIT and clear the wait counter.
- WAIT:
  - Mem_Ack=1 means the fetch is accepted.
  - Otherwise the counter increments. When the counter reaches WAIT_LIMIT, set Timeout=1 and go to HALTED. PC is unchanged.
- Fetch accepted (in FETCH or WAIT):
  - PC <= Mux_In.
  - Fetch_Valid=1 on the next cycle only.
  - Branch pending clears.
  - Next state is HALTED if halt pending or Halt=1 this cycle, else FETCH. Halt pending clears.
- HALTED:
  - Start=1 goes to FETCH, clears Timeout, keeps PC.
  - Otherwise hold.
- Branch_Req in FETCH or WAIT:
  - Without a same-cycle accept: pending=1, Next_Branch<=Branch_Addr. A later request before the accept overwrites the target.
  - With a same-cycle accept: the current update uses the previous Mux_Sel and Next_Branch; the new request sets pending for the following fetch.
- Branch_Req in IDLE: latched the same way and applied to the first fetch.
- Branch_Req in HALTED: ignored.
- Halt in FETCH or WAIT sets halt pending.
- Wrap-around: PC=8'hFF with no branch gives next PC 8'h00, with no flag.
- Steady state, Mem_Ack held 1: one PC update per cycle; Fetch_Valid stays high continuously.

Optional Feature:
- Macro: PC_LINK_EN.
- When defined, adds ports Call_Req in 1, Ret_Req in 1, Link out 8 (reset 8'h00).
  - Call_Req behaves as Branch_Req and also sets Link<=PC+1 on the accepting fetch.
  - Ret_Req behaves as a branch with target Link.
  - Priority: Ret_Req > Call_Req > Branch_Req.
- When undefined, these ports and the link register do not exist; behaviour is as above.

Test Plan:
- Reset, then Start=1, Mem_Ack=1 continuously -> PC sequence 00,01,02,03; Fetch_Valid high from the 2nd cycle after Start; Mux_Sel=0.
- PC=8'hFE, Mem_Ack=1 for 3 fetches -> PC FF,00,01; Next_Seq=00 while PC=FF.
- In WAIT, Branch_Req=1 with Branch_Addr=8'h40, Mem_Ack 2 cycles later -> Mux_Sel=1 until accept; PC=40; next PC=41.
- Branch_Req=1 (addr 8'h80) on the same cycle as Mem_Ack at PC=10 -> PC=11, then the next accept gives PC=80.
- Mem_Req with Mem_Ack=0, WAIT_LIMIT=15 -> HALTED after 15 WAIT cycles, Timeout=1, PC unchanged; Start -> FETCH, Timeout=0.
- Halt=1 in WAIT, Mem_Ack 3 cycles later -> PC updates once, State=HALTED; RST asserted mid-WAIT -> PC=RESET_PC, Mem_Req=0 next cycle.
